// File: rtl/neo_frame_arbiter.sv
// Round-robin frame arbiter sharing one NeoPixel driver load/send port among NUM_REQ producers.
// Optional idle-owner watchdog is built when NEO_ARB_TIMEOUT_EN is defined.
module neo_frame_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   load_color_in,
    input  logic [NUM_REQ-1:0]   send_it_in,
    input  logic [NUM_REQ*3-1:0] pixel_index_in,
    input  logic [NUM_REQ*2-1:0] color_index_in,
    input  logic [NUM_REQ*8-1:0] color_level_in,
    input  logic                 ready_to_load,
    input  logic                 ready_to_send,
    input  logic                 done_wait,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ready_to_load_out,
    output logic [NUM_REQ-1:0]   ready_to_send_out,
    output logic                 load_color,
    output logic                 send_it,
    output logic [2:0]           pixel_index,
    output logic [1:0]           color_index,
    output logic [7:0]           color_level,
    output logic                 timeout
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1) begin : g_bad_param
        $error("neo_frame_arbiter: NUM_REQ must be 2..4 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, OWN, SEND} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      owner_q, owner_d, owner_scan, owner_inc;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               found;
    logic               fire_load, fire_send;
    logic               expire;
    int                 idx;

    assign fire_load = (state_q == OWN) && load_color_in[owner_q] && ready_to_load;
    assign fire_send = (state_q == OWN) && send_it_in[owner_q] && ready_to_send;
    assign owner_inc = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef NEO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt_q;
    logic          timeout_q;

    // Expire on the edge where the idle count would reach TIMEOUT.
    assign expire = (state_q == OWN) && !fire_load && !fire_send
                    && (idle_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (state_q != OWN || fire_load || fire_send || expire)
                idle_cnt_q <= '0;
            else
                idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Round-robin scan: first set req bit starting at rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        owner_scan = rr_ptr_q;
        found      = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                owner_scan = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        unique case (state_q)
            IDLE: if (found) begin
                state_d             = OWN;
                owner_d             = owner_scan;
                grant_d             = '0;
                grant_d[owner_scan] = 1'b1;
            end
            OWN: if (fire_send) begin
                state_d = SEND;
            end else if (!req[owner_q] || expire) begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = owner_inc;
            end
            SEND: if (done_wait) begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = owner_inc;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
        end
    end

    assign grant             = grant_q;
    assign ready_to_load_out = grant_q & {NUM_REQ{ready_to_load}};
    assign ready_to_send_out = grant_q & {NUM_REQ{ready_to_send}};
    assign load_color        = fire_load;
    assign send_it           = fire_send;
    assign pixel_index       = fire_load ? pixel_index_in[int'(owner_q)*3 +: 3] : '0;
    assign color_index       = fire_load ? color_index_in[int'(owner_q)*2 +: 2] : '0;
    assign color_level       = fire_load ? color_level_in[int'(owner_q)*8 +: 8] : '0;

endmodule

// File: tb/tb_neo_frame_arbiter.sv
// Directed self-checking bench for neo_frame_arbiter (NUM_REQ = 2, TIMEOUT = 4).
// Watchdog expectations follow NEO_ARB_TIMEOUT_EN.
module tb_neo_frame_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0, load_color_in = '0, send_it_in = '0;
    logic [5:0]  pixel_index_in = '0;
    logic [3:0]  color_index_in = '0;
    logic [15:0] color_level_in = '0;
    logic        ready_to_load = 1'b0, ready_to_send = 1'b0, done_wait = 1'b0;
    logic [1:0]  grant, ready_to_load_out, ready_to_send_out;
    logic        load_color, send_it, timeout;
    logic [2:0]  pixel_index;
    logic [1:0]  color_index;
    logic [7:0]  color_level;

    int n_checks = 0;
    int n_fail   = 0;

    neo_frame_arbiter #(.NUM_REQ(2), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .req(req),
        .load_color_in(load_color_in), .send_it_in(send_it_in),
        .pixel_index_in(pixel_index_in), .color_index_in(color_index_in),
        .color_level_in(color_level_in),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send), .done_wait(done_wait),
        .grant(grant), .ready_to_load_out(ready_to_load_out), .ready_to_send_out(ready_to_send_out),
        .load_color(load_color), .send_it(send_it), .pixel_index(pixel_index),
        .color_index(color_index), .color_level(color_level), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_load", 32'(load_color), 32'h0);
        check("rst_send", 32'(send_it), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_level", 32'(color_level), 32'h0);
        reset = 1'b0;

        // Single requester granted one clock after req, load forwarded with its fields.
        req = 2'b01;
        tick();
        check("grant_first", 32'(grant), 32'h1);
        ready_to_load  = 1'b1;
        load_color_in  = 2'b01;
        color_level_in = 16'h0020;
        pixel_index_in = 6'b000_011;
        color_index_in = 4'b00_01;
        #1;
        check("load_fwd", 32'(load_color), 32'h1);
        check("load_level", 32'(color_level), 32'h20);
        check("load_pixel", 32'(pixel_index), 32'h3);
        check("load_cidx", 32'(color_index), 32'h1);
        check("rtl_out_owner", 32'(ready_to_load_out), 32'h1);

        // Non-owner strobes and fields are ignored.
        req            = 2'b11;
        load_color_in  = 2'b10;
        color_level_in = 16'hFF00;
        #1;
        check("nonown_load", 32'(load_color), 32'h0);
        check("nonown_level", 32'(color_level), 32'h0);
        check("nonown_rtl", 32'(ready_to_load_out), 32'h1);

        // Send blocked while driver not ready, then forwarded.
        load_color_in = 2'b00;
        send_it_in    = 2'b01;
        ready_to_send = 1'b0;
        #1;
        check("send_blocked", 32'(send_it), 32'h0);
        tick();
        check("own_held", 32'(grant), 32'h1);
        ready_to_send = 1'b1;
        #1;
        check("send_fwd", 32'(send_it), 32'h1);
        check("rts_out", 32'(ready_to_send_out), 32'h1);
        tick();
        load_color_in = 2'b01;
        #1;
        check("send_no_load", 32'(load_color), 32'h0);
        check("send_no_send", 32'(send_it), 32'h0);
        check("send_grant", 32'(grant), 32'h1);

        // done_wait releases; one dead IDLE cycle; then the other requester.
        load_color_in = 2'b00;
        send_it_in    = 2'b00;
        done_wait     = 1'b1;
        tick();
        done_wait = 1'b0;
        check("idle_gap", 32'(grant), 32'h0);
        check("idle_rtl", 32'(ready_to_load_out), 32'h0);
        tick();
        check("rr_next", 32'(grant), 32'h2);

        // Owner 1 drops req without sending: back to requester 0.
        req = 2'b01;
        tick();
        check("drop_release", 32'(grant), 32'h0);
        tick();
        check("rr_wrap", 32'(grant), 32'h1);

        // done_wait outside SEND is ignored.
        done_wait = 1'b1;
        tick();
        done_wait = 1'b0;
        check("dw_ignored", 32'(grant), 32'h1);

        // req drop in same cycle as forwarded send: SEND wins.
        ready_to_send = 1'b1;
        send_it_in    = 2'b01;
        req           = 2'b00;
        #1;
        check("drop_send_fwd", 32'(send_it), 32'h1);
        tick();
        send_it_in = 2'b00;
        check("drop_send_hold", 32'(grant), 32'h1);
        tick();
        check("send_wait", 32'(grant), 32'h1);
        done_wait = 1'b1;
        tick();
        done_wait     = 1'b0;
        ready_to_send = 1'b0;
        check("send_done", 32'(grant), 32'h0);
        tick();
        check("idle_noreq", 32'(grant), 32'h0);

        // Single requester re-granted (scan from rr_ptr=1 wraps to 0).
        req = 2'b01;
        tick();
        check("single_regrant", 32'(grant), 32'h1);
        req = 2'b11;

`ifdef NEO_ARB_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("to_hold", 32'(grant), 32'h1);
            check("to_quiet", 32'(timeout), 32'h0);
        end
        tick();
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_release", 32'(grant), 32'h0);
        tick();
        check("to_pulse_end", 32'(timeout), 32'h0);
        check("to_next_owner", 32'(grant), 32'h2);
`else
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("nto_hold", 32'(grant), 32'h1);
            check("nto_quiet", 32'(timeout), 32'h0);
        end
`endif

        // Asynchronous reset mid-frame kills strobes immediately.
        ready_to_load = 1'b1;
        load_color_in = 2'b11;
        #1;
        check("pre_rst_load", 32'(load_color), 32'h1);
        reset = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_load", 32'(load_color), 32'h0);
        check("arst_level", 32'(color_level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neo_frame_arbiter.md
# neo_frame_arbiter

Shares one NeoPixel driver load/send port between up to four pattern producers. A producer owns the port for a whole frame: every load of that frame plus the one send. The frame ends when the driver reports `done_wait`, and ownership then passes to the next requester in round-robin order. The block sits between the producer FSMs and the NeoPixel driver, forwarding the owner's `load_color`/`send_it` and colour fields and routing the driver's ready signals only to that owner.

## Interface
- `NUM_REQ`, default 2: number of producers; legal 2..4.
- `TIMEOUT`, default 255: idle-owner cycle limit; used only with `NEO_ARB_TIMEOUT_EN`.

- `clock`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `NUM_REQ`: per-producer frame request, level, held until frame done.
- `load_color_in`, input, `NUM_REQ`: per-producer load strobe.
- `send_it_in`, input, `NUM_REQ`: per-producer send strobe.
- `pixel_index_in`, input, `NUM_REQ`x3: per-producer pixel index.
- `color_index_in`, input, `NUM_REQ`x2: per-producer colour index (0 = G, 1 = R, 2 = B).
- `color_level_in`, input, `NUM_REQ`x8: per-producer colour level.
- `ready_to_load`, input, 1: from driver.
- `ready_to_send`, input, 1: from driver.
- `done_wait`, input, 1: from driver; frame latch time complete.
- `grant`, output, `NUM_REQ`: one-hot owner, registered.
- `ready_to_load_out`, output, `NUM_REQ`: `ready_to_load` gated to owner.
- `ready_to_send_out`, output, `NUM_REQ`: `ready_to_send` gated to owner.
- `load_color`, output, 1: to driver.
- `send_it`, output, 1: to driver.
- `pixel_index`, output, 3: to driver.
- `color_index`, output, 2: to driver.
- `color_level`, output, 8: to driver.
- `timeout`, output, 1: one-cycle pulse on forced release.

## Operation
- States: IDLE, OWN, SEND. Reset enters IDLE with `grant` = 0, `rr_ptr` = 0, all outputs 0.
- IDLE → OWN:
  - Triggered when any `req` bit is set.
  - Owner is the first set bit scanning from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - `grant` is registered on that edge.
- OWN, load path:
  - `load_color` = `load_color_in[owner] & ready_to_load`.
  - `pixel_index`, `color_index` and `color_level` are muxed from the owner.
- OWN, send path:
  - `send_it` = `send_it_in[owner] & ready_to_send`.
  - A forwarded `send_it` moves the FSM to SEND.
  - Strobes from an owner whose driver ready signal is low are dropped, not queued.
- Non-owners see `ready_to_*_out` = 0. Their strobes and fields are ignored.
- Data fields are 0 whenever `load_color` is 0.
- OWN → IDLE without a send: happens when `req[owner]` drops.
  - Grant is released and `rr_ptr` = owner+1 mod `NUM_REQ`.
  - A forwarded `send_it` in the same cycle as `req` dropping wins: go to SEND.
- SEND:
  - All driver outputs are 0 and the grant is held.
  - On `done_wait` = 1, release the grant, advance `rr_ptr` as above, and return to IDLE.
- `done_wait` outside SEND is ignored.
- A single requester is re-granted on every frame. A requester cannot be granted twice in a row while another is requesting.

## Timing
- Grant latency: `req` sampled high in IDLE → `grant` high one clock later.
- Pass-through: `load_color` and `send_it` are combinational from the owner strobe and the driver ready signal, so there is zero added latency.
- Release: the `done_wait` edge → IDLE. The next grant comes no earlier than one clock later, giving a minimum of one dead IDLE cycle between frames.
- `rr_ptr` and `grant` change only on clock edges. `grant` never has more than one bit set.
- Reset mid-frame asynchronously clears `grant` and forces `load_color`/`send_it` low immediately, with no partial-send recovery.

## Configuration
- Macro `NEO_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(`TIMEOUT`+1) runs in OWN.
  - It clears on every forwarded `load_color` or `send_it`, and increments otherwise.
  - When it reaches `TIMEOUT`: release the grant, advance `rr_ptr`, go to IDLE, and pulse `timeout` for one cycle.
  - The counter clears on entry to OWN and does not run in SEND.
- Macro undefined: no counter is built, `timeout` is tied to 0, and an owner may hold the port indefinitely.

## Test plan
- Reset, then `req` = 2'b01. Expected: `grant` = 01 on the next clock. With `ready_to_load` = 1, `load_color_in[0]` with level 8'h20 → `load_color` = 1, `color_level` = 8'h20.
- `req` = 2'b11 from IDLE with `rr_ptr` = 0. Expected: grant 01. Requester 0 sends, then `done_wait` → grant 10 after one IDLE cycle. The second frame then goes back to 01.
- Owner 0 in OWN, `ready_to_send` = 0, `send_it_in[0]` = 1. Expected: `send_it` = 0 and state stays OWN. Raising `ready_to_send` → `send_it` = 1, then SEND.
- Requester 1 not granted drives `load_color_in[1]` = 1, level 8'hFF. Expected: `load_color` = 0, `color_level` = 0, `ready_to_load_out[1]` = 0.
- `req[0]` drops in the same cycle as a forwarded `send_it`. Expected: state becomes SEND and the grant is held until `done_wait`.
- With `NEO_ARB_TIMEOUT_EN`, `TIMEOUT` = 4: the owner issues no strobes. Expected: 4 cycles after the grant, `timeout` pulses for 1 cycle, `grant` = 0, and the other requester is granted next.
